// File: rtl/mor1kx_spram_init_ctrl.sv
// Front-end for a single-port write-first RAM: clears every word after reset or flush, then passes client requests through.
// Latency: accept is combinational (ack_o = req_i when ready); rvalid_o and rdata_o follow one cycle after an accepted read.
// Backpressure: none while ready; while busy_o is high requests are ignored (ack_o = 0) and the RAM port is owned by the sweep.
module mor1kx_spram_init_ctrl #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   output logic                  busy_o,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic                  ack_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_din_o,
   input  logic [DATA_WIDTH-1:0] ram_dout_i
);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_CLEAR,
      ST_READY
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_nxt;

   // State and sweep counter register; the counter wrapping to zero marks the end of a sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic and RAM port ownership: sweep writes in CLEAR, client pass-through in READY.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ram_en_o   = 1'b0;
      ram_we_o   = 1'b0;
      ram_addr_o = cnt;
      ram_din_o  = INIT_VALUE;
      ack_o      = 1'b0;
      case (state)
         ST_INIT: begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
         end
         ST_CLEAR: begin
            ram_en_o = 1'b1;
            ram_we_o = 1'b1;
            if (flush_i) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         ST_READY: begin
            ram_en_o   = req_i;
            ram_we_o   = we_i;
            ram_addr_o = addr_i;
            ram_din_o  = din_i;
            ack_o      = req_i;
            // A request in the flush cycle still completes; the sweep starts on the same edge.
            if (flush_i) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Read-valid strobe: one cycle after each accepted read, never after writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_o <= 1'b0;
      end else begin
         rvalid_o <= ack_o & ~we_i;
      end
   end

   assign busy_o  = (state != ST_READY);
   assign rdata_o = ram_dout_i;

endmodule

// File: tb/tb_mor1kx_spram_init_ctrl.sv
module tb_mor1kx_spram_init_ctrl;

   localparam int          AW    = 4;
   localparam int          DW    = 32;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] IV    = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush, busy, req, we, ack, rvalid;
   logic [AW-1:0] addr;
   logic [DW-1:0] din, rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   always #5 clk = ~clk;

   mor1kx_spram_init_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .INIT_VALUE(IV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .busy_o     (busy),
      .req_i      (req),
      .we_i       (we),
      .addr_i     (addr),
      .din_i      (din),
      .ack_o      (ack),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .ram_en_o   (ram_en),
      .ram_we_o   (ram_we),
      .ram_addr_o (ram_addr),
      .ram_din_o  (ram_din),
      .ram_dout_i (ram_dout)
   );

   // Write-first synchronous RAM attached to the controller
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
         end else begin
            ram_dout <= ram[ram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: position in the access schedule (-1 idle cycle before sweep,
   // 0..DEPTH-1 word being cleared, DEPTH ready) plus expected memory contents.
   int            m_pos = -1;
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_rvalid = 1'b0;
   logic [DW-1:0] m_dout;
   bit            m_dout_known = 0;
   logic          e_en, e_we, e_ack;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din;

   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            m_pos    = -1;
            m_rvalid = 1'b0;
            check("rst_busy", busy, 1);
            check("rst_ack", ack, 0);
            check("rst_en", ram_en, 0);
            check("rst_rvalid", rvalid, 0);
         end else begin
            e_ack = 1'b0; e_addr = '0; e_din = '0;
            if (m_pos < 0) begin
               e_en = 1'b0; e_we = 1'b0;
            end else if (m_pos < DEPTH) begin
               e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_pos); e_din = IV;
            end else begin
               e_en = req; e_we = we; e_addr = addr; e_din = din; e_ack = req;
            end
            check("busy", busy, (m_pos != DEPTH));
            check("ack", ack, e_ack);
            check("ram_en", ram_en, e_en);
            if (e_en) begin
               check("ram_we", ram_we, e_we);
               check("ram_addr", ram_addr, e_addr);
               if (e_we) check("ram_din", ram_din, e_din);
            end
            check("rvalid", rvalid, m_rvalid);
            if (m_dout_known) check("rdata", rdata, m_dout);
            // advance the model across the coming rising edge
            m_rvalid = e_ack & ~we;
            if (e_en) begin
               if (e_we) m_mem[e_addr] = e_din;
               m_dout = m_mem[e_addr];
               m_dout_known = 1;
            end
            if (m_pos < 0) m_pos = 0;
            else if (flush) m_pos = 0;
            else if (m_pos < DEPTH) m_pos = m_pos + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles_until_ready(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (busy && n < 60);
   endtask

   task automatic busy_count(output int k);
      k = 0;
      while (busy && k < 100) begin
         k++;
         step();
      end
   endtask

   int n;
   logic [31:0] vals [3];

   initial begin
      flush = 0; req = 0; we = 0; addr = '0; din = '0;
      vals[0] = 32'hA1A1_0001; vals[1] = 32'hB2B2_0002; vals[2] = 32'hC3C3_0003;
      #2 rst_n = 1'b0;
      #1 chk_en = 1;
      req = 1; #1;
      check("init_busy", busy, 1);
      check("init_ack", ack, 0);
      check("init_en", ram_en, 0);
      check("init_we", ram_we, 0);
      check("init_rvalid", rvalid, 0);
      req = 0;
      step(); step();
      rst_n = 1'b1;
      cycles_until_ready(n);
      check("busy_fall_edge", n, 17);

      // reads after the initial sweep
      req = 1; we = 0;
      addr = 4'd0;  step(); check("rd0", rdata, IV);
      addr = 4'd7;  step(); check("rd7", rdata, IV);
      addr = 4'd15; step(); check("rd15", rdata, IV); check("rd15_v", rvalid, 1);

      // write then read same address
      we = 1; addr = 4'd3; din = 32'h1234_5678; #1;
      check("wr_ack", ack, 1);
      step();
      check("wr_no_rvalid", rvalid, 0);
      we = 0; #1;
      check("rd_ack", ack, 1);
      step();
      check("rd3_v", rvalid, 1);
      check("rd3", rdata, 32'h1234_5678);

      // back-to-back reads with distinct data
      we = 1;
      for (int i = 0; i < 3; i++) begin
         addr = AW'(i + 1); din = vals[i]; step();
      end
      we = 0;
      for (int i = 0; i < 3; i++) begin
         addr = AW'(i + 1); step();
         check("b2b_v", rvalid, 1);
         check("b2b_d", rdata, vals[i]);
      end
      req = 0; step();
      check("idle_v", rvalid, 0);
      check("idle_hold", rdata, vals[2]);

      // flush together with a write
      flush = 1; req = 1; we = 1; addr = 4'd5; din = 32'h5555_AAAA; #1;
      check("flush_wr_ack", ack, 1);
      step();
      flush = 0; req = 0; we = 0;
      busy_count(n);
      check("flush_busy_len", n, 16);
      req = 1; addr = 4'd5; step(); req = 0;
      check("rd5_cleared", rdata, IV);

      // reset pulse mid-sweep at address 9
      flush = 1; step(); flush = 0;
      repeat (9) step();
      check("sweep_at9", ram_addr, 9);
      rst_n = 1'b0; #1;
      check("async_busy", busy, 1);
      check("async_en", ram_en, 0);
      check("async_we", ram_we, 0);
      check("async_rvalid", rvalid, 0);
      step(); step();
      rst_n = 1'b1;
      req = 1; we = 0; addr = 4'd2;
      step();
      check("restart_addr0", ram_addr, 0);
      check("sweep_req_ack", ack, 0);
      busy_count(n);
      check("restart_len", n, 16);
      req = 0;

      // flush at sweep address 10
      flush = 1; step(); flush = 0;
      repeat (10) step();
      check("sweep_at10", ram_addr, 10);
      flush = 1; step(); flush = 0;
      check("reflush_addr0", ram_addr, 0);
      busy_count(n);
      check("reflush_len", n, 16);

      // randomized traffic with occasional flushes
      for (int i = 0; i < 800; i++) begin
         req   = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         addr  = AW'($urandom_range(0, DEPTH - 1));
         din   = $urandom;
         flush = ($urandom_range(0, 59) == 0);
         step();
      end
      flush = 0; req = 0;
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
